// File: rtl/biu_arb_pkg.sv
// biu_arb_pkg: shared types for the BIU round-robin arbiter.
// Holds the arbiter FSM state encoding.
package biu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } biu_arb_state_t;

endpackage

// File: rtl/biu_master_if.sv
// biu_master_if: en/busy handshake port of the bus interface unit.
// The device modport is the side that issues requests into the BIU.
interface biu_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  en;
  logic                  rnw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  data_valid;

  modport device (
    output en,
    output rnw,
    output address,
    output data_out,
    input  data_in,
    input  busy,
    input  data_valid
  );

  modport host (
    input  en,
    input  rnw,
    input  address,
    input  data_out,
    output data_in,
    output busy,
    output data_valid
  );

endinterface

// File: rtl/biu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
// Rotate so the search starts after last_gnt, find-first, un-rotate.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt_i,
  output logic                       any_req_o,
  output logic [$clog2(NUM_REQ)-1:0] winner_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;

  logic [IW-1:0]        start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW-1:0]        off;
  logic                 found;
  logic [SW-1:0]        sum;

  assign any_req_o = |req_i;

  // rotate, pick lowest set bit, map the offset back to a requester index
  always_comb begin
    start = '0;
    if (last_gnt_i != IW'(NUM_REQ - 1)) begin
      start = last_gnt_i + IW'(1);
    end
    dbl   = {req_i, req_i} >> start;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        off   = IW'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= SW'(NUM_REQ)) begin
      sum = sum - SW'(NUM_REQ);
    end
    winner_o = sum[IW-1:0];
  end

endmodule

// File: rtl/biu_arbiter.sv
// biu_arbiter: round-robin sharing of one BIU between NUM_REQ masters.
// One transaction in flight; read timeout returns all-ones with err.
module biu_arbiter
  import biu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic [NUM_REQ-1:0]                  req_en,
  input  logic [NUM_REQ-1:0]                  req_rnw,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  req_ack,
  output logic [DATA_WIDTH-1:0]               req_rd_data,
  output logic                                req_err,
  output logic [$clog2(NUM_REQ)-1:0]          gnt_id,
  biu_master_if.device                        biu
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(RD_TIMEOUT);

  biu_arb_state_t        state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rnw_q;
  logic                  en_q;
  logic [IW-1:0]         gnt_q;
  logic [IW-1:0]         last_q;
  logic [TW-1:0]         tmo_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  err_q;

  logic                  any_req;
  logic [IW-1:0]         win;
  logic [NUM_REQ-1:0]    ack_d;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req_i     (req_en),
    .last_gnt_i(last_q),
    .any_req_o (any_req),
    .winner_o  (win)
  );

  // one-hot ack pattern for the current grant
  always_comb begin
    ack_d        = '0;
    ack_d[gnt_q] = 1'b1;
  end

  // arbiter FSM with holding registers and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      rnw_q     <= 1'b0;
      en_q      <= 1'b0;
      gnt_q     <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      tmo_q     <= '0;
      ack_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            addr_q  <= req_address[win];
            data_q  <= req_data[win];
            rnw_q   <= req_rnw[win];
            gnt_q   <= win;
            last_q  <= win;
            en_q    <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!biu.busy) begin
            en_q <= 1'b0;
            if (rnw_q) begin
              tmo_q   <= '0;
              state_q <= WAIT_RD;
            end else begin
              err_q   <= 1'b0;
              ack_q   <= ack_d;
              state_q <= DONE;
            end
          end
        end
        WAIT_RD: begin
          if (biu.data_valid) begin
            rd_data_q <= biu.data_in;
            err_q     <= 1'b0;
            ack_q     <= ack_d;
            state_q   <= DONE;
          end else if (tmo_q == TMO_LAST) begin
            rd_data_q <= '1;
            err_q     <= 1'b1;
            ack_q     <= ack_d;
            state_q   <= DONE;
          end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign biu.en       = en_q;
  assign biu.rnw      = rnw_q;
  assign biu.address  = addr_q;
  assign biu.data_out = data_q;

  assign req_ack     = ack_q;
  assign req_rd_data = rd_data_q;
  assign req_err     = err_q;
  assign gnt_id      = gnt_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// tb_biu_arbiter: directed scenarios for the BIU round-robin arbiter.
// Each task drives its own vectors and checks hand-computed values.
module tb_biu_arbiter;

  logic            clk;
  logic            n_rst;
  logic [3:0]      req_en;
  logic [3:0]      req_rnw;
  logic [3:0][31:0] req_address;
  logic [3:0][31:0] req_data;
  logic [3:0]      req_ack;
  logic [31:0]     req_rd_data;
  logic            req_err;
  logic [1:0]      gnt_id;

  int total = 0;
  int bad   = 0;

  biu_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  biu_arbiter #(
    .NUM_REQ   (4),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RD_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_en     (req_en),
    .req_rnw    (req_rnw),
    .req_address(req_address),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .req_rd_data(req_rd_data),
    .req_err    (req_err),
    .gnt_id     (gnt_id),
    .biu        (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_en = '0;
    bif.busy = 1'b0;
    bif.data_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    total++; if (bif.en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", bif.en); end
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0000", req_ack); end
    total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL rst_gnt got=%0d exp=0", gnt_id); end
    total++; if (req_rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", req_rd_data); end
    total++; if (req_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", req_err); end
    total++; if (bif.address !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bif.address); end
    total++; if (bif.data_out !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0", bif.data_out); end
    total++; if (bif.rnw !== 1'b0) begin bad++; $display("FAIL rst_rnw got=%b exp=0", bif.rnw); end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_write();
    req_en = 4'b0100;
    req_rnw[2] = 1'b0;
    req_address[2] = 32'h100;
    req_data[2] = 32'hDEADBEEF;
    tick();
    total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL wr_en got=%b exp=1", bif.en); end
    total++; if (bif.address !== 32'h100) begin bad++; $display("FAIL wr_addr got=%h exp=100", bif.address); end
    total++; if (bif.data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_dout got=%h exp=deadbeef", bif.data_out); end
    total++; if (bif.rnw !== 1'b0) begin bad++; $display("FAIL wr_rnw got=%b exp=0", bif.rnw); end
    total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL wr_gnt got=%0d exp=2", gnt_id); end
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL wr_ack_early got=%b exp=0000", req_ack); end
    tick();
    total++; if (bif.en !== 1'b0) begin bad++; $display("FAIL wr_en_drop got=%b exp=0", bif.en); end
    total++; if (req_ack !== 4'b0100) begin bad++; $display("FAIL wr_ack got=%b exp=0100", req_ack); end
    total++; if (req_err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", req_err); end
    req_en = '0;
    tick();
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL wr_ack_pulse got=%b exp=0000", req_ack); end
    total++; if (bif.en !== 1'b0) begin bad++; $display("FAIL wr_en_idle got=%b exp=0", bif.en); end
  endtask

  task automatic test_rr_reads();
    int n;
    int id;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_address[i] = 32'h1000 + 32'(i * 16);
      req_data[i] = 32'h0;
    end
    req_rnw = 4'hF;
    req_en = 4'hF;
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      n = 0;
      while (bif.en !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL rr_wait_en k=%0d got=%b exp=1", k, bif.en); end
      total++; if (gnt_id !== 2'(id)) begin bad++; $display("FAIL rr_gnt k=%0d got=%0d exp=%0d", k, gnt_id, id); end
      total++; if (bif.address !== 32'h1000 + 32'(id * 16)) begin bad++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, bif.address, 32'h1000 + 32'(id * 16)); end
      tick();
      tick();
      tick();
      bif.data_valid = 1'b1;
      bif.data_in = 32'hA0 + 32'(id);
      tick();
      bif.data_valid = 1'b0;
      total++; if (req_ack !== 4'(1 << id)) begin bad++; $display("FAIL rr_ack k=%0d got=%b exp=%b", k, req_ack, 4'(1 << id)); end
      total++; if (req_rd_data !== 32'hA0 + 32'(id)) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, req_rd_data, 32'hA0 + 32'(id)); end
      total++; if (req_err !== 1'b0) begin bad++; $display("FAIL rr_err k=%0d got=%b exp=0", k, req_err); end
      if (k == 4) req_en = '0;
    end
    tick();
    tick();
  endtask

  task automatic test_busy();
    bif.busy = 1'b1;
    req_rnw[1] = 1'b0;
    req_address[1] = 32'h200;
    req_data[1] = 32'h12345678;
    req_en = 4'b0010;
    tick();
    for (int i = 0; i < 6; i++) begin
      total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL busy_en i=%0d got=%b exp=1", i, bif.en); end
      total++; if (bif.address !== 32'h200) begin bad++; $display("FAIL busy_addr i=%0d got=%h exp=200", i, bif.address); end
      total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL busy_ack i=%0d got=%b exp=0000", i, req_ack); end
      if (i == 5) bif.busy = 1'b0;
      tick();
    end
    total++; if (bif.en !== 1'b0) begin bad++; $display("FAIL busy_en_drop got=%b exp=0", bif.en); end
    total++; if (req_ack !== 4'b0010) begin bad++; $display("FAIL busy_ack got=%b exp=0010", req_ack); end
    req_en = '0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    req_rnw[3] = 1'b1;
    req_address[3] = 32'h300;
    req_en = 4'b1000;
    tick();
    total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL tmo_en got=%b exp=1", bif.en); end
    tick();
    total++; if (bif.en !== 1'b0) begin bad++; $display("FAIL tmo_accept got=%b exp=0", bif.en); end
    for (int j = 0; j < 3; j++) begin
      tick();
      total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL tmo_early j=%0d got=%b exp=0000", j, req_ack); end
    end
    tick();
    total++; if (req_ack !== 4'b1000) begin bad++; $display("FAIL tmo_ack got=%b exp=1000", req_ack); end
    total++; if (req_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", req_err); end
    total++; if (req_rd_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL tmo_data got=%h exp=ffffffff", req_rd_data); end
    req_rnw[0] = 1'b1;
    req_address[0] = 32'h400;
    req_en = 4'b0001;
    n = 0;
    while (bif.en !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL tmo_next_en got=%b exp=1", bif.en); end
    tick();
    bif.data_valid = 1'b1;
    bif.data_in = 32'h55;
    tick();
    bif.data_valid = 1'b0;
    total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL tmo_next_ack got=%b exp=0001", req_ack); end
    total++; if (req_rd_data !== 32'h55) begin bad++; $display("FAIL tmo_next_data got=%h exp=55", req_rd_data); end
    total++; if (req_err !== 1'b0) begin bad++; $display("FAIL tmo_next_err got=%b exp=0", req_err); end
    req_en = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    req_rnw[2] = 1'b1;
    req_address[2] = 32'h500;
    req_en = 4'b0100;
    n = 0;
    while (bif.en !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL mid_gnt_pre got=%0d exp=2", gnt_id); end
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    total++; if (bif.en !== 1'b0) begin bad++; $display("FAIL mid_en got=%b exp=0", bif.en); end
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL mid_ack got=%b exp=0000", req_ack); end
    total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL mid_gnt got=%0d exp=0", gnt_id); end
    total++; if (bif.address !== 32'h0) begin bad++; $display("FAIL mid_addr got=%h exp=0", bif.address); end
    req_rnw = 4'b0;
    req_address[0] = 32'h600;
    req_address[1] = 32'h610;
    req_address[3] = 32'h630;
    req_en = 4'b1011;
    #1;
    n_rst = 1'b1;
    tick();
    total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL mid_after_en got=%b exp=1", bif.en); end
    total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL mid_after_gnt got=%0d exp=0", gnt_id); end
    total++; if (bif.address !== 32'h600) begin bad++; $display("FAIL mid_after_addr got=%h exp=600", bif.address); end
    tick();
    total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL mid_after_ack got=%b exp=0001", req_ack); end
    req_en = '0;
    tick();
    tick();
  endtask

  task automatic test_dv_ignored();
    bif.data_valid = 1'b1;
    bif.data_in = 32'hBAD;
    tick();
    bif.data_valid = 1'b0;
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL dv_idle_ack got=%b exp=0000", req_ack); end
    total++; if (req_rd_data !== 32'h0) begin bad++; $display("FAIL dv_idle_data got=%h exp=0", req_rd_data); end
    bif.busy = 1'b1;
    req_rnw[1] = 1'b1;
    req_address[1] = 32'h700;
    req_en = 4'b0010;
    tick();
    bif.data_valid = 1'b1;
    bif.data_in = 32'hBAD2;
    tick();
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL dv_issue_ack got=%b exp=0000", req_ack); end
    total++; if (req_rd_data !== 32'h0) begin bad++; $display("FAIL dv_issue_data got=%h exp=0", req_rd_data); end
    total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL dv_issue_en got=%b exp=1", bif.en); end
    bif.data_valid = 1'b0;
    bif.busy = 1'b0;
    tick();
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL dv_wait_ack got=%b exp=0000", req_ack); end
    bif.data_valid = 1'b1;
    bif.data_in = 32'h77;
    tick();
    bif.data_valid = 1'b0;
    total++; if (req_ack !== 4'b0010) begin bad++; $display("FAIL dv_ack got=%b exp=0010", req_ack); end
    total++; if (req_rd_data !== 32'h77) begin bad++; $display("FAIL dv_data got=%h exp=77", req_rd_data); end
    req_en = '0;
    tick();
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL dv_ack_pulse got=%b exp=0000", req_ack); end
    total++; if (req_rd_data !== 32'h77) begin bad++; $display("FAIL dv_hold got=%h exp=77", req_rd_data); end
  endtask

  task automatic test_back_to_back();
    req_rnw = 4'b0;
    req_address[0] = 32'h800;
    req_address[1] = 32'h900;
    req_en = 4'b0011;
    tick();
    total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL b2b_gnt0 got=%0d exp=0", gnt_id); end
    tick();
    total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL b2b_ack0 got=%b exp=0001", req_ack); end
    req_en[0] = 1'b0;
    tick();
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0000", req_ack); end
    tick();
    total++; if (bif.en !== 1'b1) begin bad++; $display("FAIL b2b_en1 got=%b exp=1", bif.en); end
    total++; if (gnt_id !== 2'd1) begin bad++; $display("FAIL b2b_gnt1 got=%0d exp=1", gnt_id); end
    total++; if (bif.address !== 32'h900) begin bad++; $display("FAIL b2b_addr1 got=%h exp=900", bif.address); end
    tick();
    total++; if (req_ack !== 4'b0010) begin bad++; $display("FAIL b2b_ack1 got=%b exp=0010", req_ack); end
    req_en = '0;
    tick();
  endtask

  initial begin
    n_rst = 1'b0;
    req_en = '0;
    req_rnw = '0;
    req_address = '0;
    req_data = '0;
    bif.busy = 1'b0;
    bif.data_valid = 1'b0;
    bif.data_in = '0;
    test_reset();
    test_write();
    test_rr_reads();
    test_busy();
    test_timeout();
    test_reset_mid();
    test_dv_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
